mips_trace_checker: RTL
=======================

MIPS_TRACE_CHECKER -- requirements
Module: mips_trace_checker

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of observed channels.
REQ-002 SHALL have parameter CH_W, default 32: bits per channel.
REQ-003 SHALL have parameter DEPTH, default 128: expected-vector storage entries.
REQ-004 SHALL have parameter NUM_VEC, default 93: vectors checked before done; legal range 1..DEPTH.
REQ-005 SHALL have port clk, input, 1: single clock, all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port ld_en, input, 1: write one expected vector.
REQ-008 SHALL have port ld_addr, input, $clog2(DEPTH): expected-vector write index.
REQ-009 SHALL have port ld_data, input, NUM_CH*CH_W: expected values, channel 0 in LSBs.
REQ-010 SHALL have port start, input, 1: begin a check run.
REQ-011 SHALL have port sample, input, 1: compare obs against the current vector this cycle.
REQ-012 SHALL have port obs, input, NUM_CH*CH_W: observed DUT values, channel 0 in LSBs.
REQ-013 SHALL have port busy, output, 1: run in progress.
REQ-014 SHALL have port done, output, 1: run complete, held until next start or reset.
REQ-015 SHALL have port vec_num, output, 16: index of the next vector to check.
REQ-016 SHALL have port err_count, output, 16: saturating mismatch-vector count.
REQ-017 SHALL have port err_pulse, output, 1: one-cycle flag for a mismatching sample.
REQ-018 SHALL have port err_ch, output, NUM_CH: per-channel mismatch mask of the last failing sample.
REQ-019 SHALL have port first_err_vec, output, 16: vector index of the first mismatch, 16'hFFFF if none.

Function
REQ-020 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when the NUM_VEC-th sample is taken; DONE -> RUN on start.
REQ-021 SHALL clear vec_num, err_count, err_ch and first_err_vec, set first_err_vec to 16'hFFFF, on any start that is accepted.
REQ-022 SHALL ignore sample outside RUN.
REQ-023 SHALL, on a sample in RUN, compare each channel of obs to the stored vector[vec_num] and register the results; err_pulse, err_ch, err_count and vec_num SHALL update one cycle after the sample cycle.
REQ-024 SHALL count a vector as one error regardless of how many channels mismatch.
REQ-025 SHALL saturate err_count at 16'hFFFF.
REQ-026 SHALL capture first_err_vec only on the first mismatch of a run.
REQ-027 SHALL assert done and deassert busy in the same cycle that the final vec_num update occurs.
REQ-028 SHALL give start priority over sample when both are asserted in RUN: the run restarts and the sample is dropped.
REQ-029 SHALL accept ld_en in any state; a write to the entry being compared in the same cycle SHALL compare against the old contents.
REQ-030 SHALL ignore ld_addr values >= DEPTH.

Reset
REQ-031 SHALL, on reset low at a rising edge, enter IDLE with busy=0, done=0, vec_num=0, err_count=0, err_pulse=0, err_ch=0, first_err_vec=16'hFFFF.
REQ-032 SHALL leave vector storage contents unchanged by reset.
REQ-033 SHALL abort a run on reset mid-RUN with no done assertion.

Configuration
REQ-034 SHALL, with TRACE_CHECK_MASK_EN defined, add input ld_mask (NUM_CH*CH_W) stored with each vector; a bit set to 1 in the mask marks the corresponding bit as don't-care and excludes it from the comparison.
REQ-035 SHALL, without TRACE_CHECK_MASK_EN, have no ld_mask port and compare every bit.

Structure
REQ-036 SHALL place the state enum, the 16'hFFFF no-error constant and the count width in package mips_trace_pkg.
REQ-037 SHALL implement vector storage as sub-module mips_trace_rom, a single-write-port, single-read-port synchronous-write memory with combinational read.

Verification
REQ-038 SHALL cover: load 4 vectors, NUM_VEC=4, obs match on every sample -> done after the 4th sample, err_count=0, first_err_vec=FFFF.
REQ-039 SHALL cover: vector 2 channel 1 off by one -> err_pulse on one cycle, err_ch=4'b0010, err_count=1, first_err_vec=2.
REQ-040 SHALL cover: all channels mismatch on vectors 1 and 3 -> err_count=2, first_err_vec=1, err_ch=4'b1111.
REQ-041 SHALL cover: start and sample asserted together in RUN at vec_num=3 -> vec_num=0, err_count=0, the sample is not counted.
REQ-042 SHALL cover: reset low at vec_num=2 mid-run -> IDLE, done=0, vector contents intact and rerun passes.
REQ-043 SHALL cover: with TRACE_CHECK_MASK_EN defined and mask=32'h0000_00FF on channel 0, obs differing only in bits 7:0 -> no error.

Source files
------------

// File: rtl/mips_trace_pkg.sv
// mips_trace_pkg: shared types and constants for the trace checker.
//   state_t  - checker run state (IDLE / RUN / DONE)
//   CNT_W    - width of vec_num, err_count and first_err_vec
//   NO_ERR   - first_err_vec value when no mismatch has been seen
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] NO_ERR = 16'hFFFF;

endpackage

// File: rtl/mips_trace_rom.sv
// mips_trace_rom: expected-vector storage.
// One synchronous write port, one combinational read port. Contents are
// never cleared by reset. Writes to indices >= DEPTH are discarded.
// Ports:
//   clk        - clock
//   i_wr_en    - write strobe
//   i_wr_addr  - write index
//   i_wr_data  - write data
//   i_rd_addr  - read index
//   o_rd_data  - read data (combinational)
module mips_trace_rom #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 128,
  parameter int unsigned AW    = 7
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic         w_addr_ok;

  assign w_addr_ok = (int'(i_wr_addr) < int'(DEPTH));

  always_ff @(posedge clk) begin
    if (i_wr_en && w_addr_ok) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Combinational read: a same-cycle write is only visible after the edge,
  // so a compare in that cycle sees the old contents.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mips_trace_checker.sv
// mips_trace_checker: compares sampled DUT observations against a table of
// expected vectors and reports mismatches.
// Optional feature macro: TRACE_CHECK_MASK_EN adds ld_mask, a per-bit
// don't-care mask stored with each vector (1 = ignore bit).
// Ports:
//   clk, reset     - clock, synchronous active-low reset
//   ld_en/addr/data- expected-vector write port (channel 0 in LSBs)
//   ld_mask        - don't-care mask (only with TRACE_CHECK_MASK_EN)
//   start          - begin/restart a run
//   sample, obs    - compare obs against vector[vec_num]
//   busy, done     - run status
//   vec_num        - index of next vector to check
//   err_count      - saturating count of mismatching vectors
//   err_pulse      - one-cycle flag for a mismatching sample
//   err_ch         - channel mismatch mask of the last failing sample
//   first_err_vec  - index of first mismatch in the run, FFFF if none
module mips_trace_checker
  import mips_trace_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CH_W    = 32,
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned NUM_VEC = 93,
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned VW     = NUM_CH * CH_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [VW-1:0]     ld_data,
`ifdef TRACE_CHECK_MASK_EN
  input  logic [VW-1:0]     ld_mask,
`endif
  input  logic              start,
  input  logic              sample,
  input  logic [VW-1:0]     obs,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_num,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_pulse,
  output logic [NUM_CH-1:0] err_ch,
  output logic [CNT_W-1:0]  first_err_vec
);

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic [CNT_W-1:0]   r_vec_num;
  logic [CNT_W-1:0]   r_err_count;
  logic               r_err_pulse;
  logic [NUM_CH-1:0]  r_err_ch;
  logic [CNT_W-1:0]   r_first_err;

  logic [VW-1:0]      w_exp;
  logic [VW-1:0]      w_msk;
  logic [NUM_CH-1:0]  w_mis;
  logic [CNT_W-1:0]   w_vec_nxt;

`ifdef TRACE_CHECK_MASK_EN
  logic [2*VW-1:0]    w_rd;

  mips_trace_rom #(
    .W     (2 * VW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .clk       (clk),
    .i_wr_en   (ld_en),
    .i_wr_addr (ld_addr),
    .i_wr_data ({ld_mask, ld_data}),
    .i_rd_addr (r_vec_num[AW-1:0]),
    .o_rd_data (w_rd)
  );

  assign w_exp = w_rd[VW-1:0];
  assign w_msk = w_rd[2*VW-1:VW];
`else
  mips_trace_rom #(
    .W     (VW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .clk       (clk),
    .i_wr_en   (ld_en),
    .i_wr_addr (ld_addr),
    .i_wr_data (ld_data),
    .i_rd_addr (r_vec_num[AW-1:0]),
    .o_rd_data (w_exp)
  );

  assign w_msk = '0;
`endif

  always_comb begin
    w_mis = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_mis[c] = |((obs[c*CH_W +: CH_W] ^ w_exp[c*CH_W +: CH_W]) &
                   ~w_msk[c*CH_W +: CH_W]);
    end
  end

  assign w_vec_nxt = r_vec_num + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_vec_num   <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
      r_err_ch    <= '0;
      r_first_err <= NO_ERR;
    end else begin
      r_err_pulse <= 1'b0;
      if (start) begin
        // Start wins over a coincident sample in every state.
        r_state     <= ST_RUN;
        r_busy      <= 1'b1;
        r_done      <= 1'b0;
        r_vec_num   <= '0;
        r_err_count <= '0;
        r_err_ch    <= '0;
        r_first_err <= NO_ERR;
      end else if (r_state == ST_RUN && sample) begin
        r_vec_num <= w_vec_nxt;
        if (|w_mis) begin
          r_err_pulse <= 1'b1;
          r_err_ch    <= w_mis;
          if (r_err_count != '1) begin
            r_err_count <= r_err_count + 1'b1;
          end
          if (r_err_count == '0) begin
            r_first_err <= r_vec_num;
          end
        end
        if (w_vec_nxt == CNT_W'(NUM_VEC)) begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign vec_num       = r_vec_num;
  assign err_count     = r_err_count;
  assign err_pulse     = r_err_pulse;
  assign err_ch        = r_err_ch;
  assign first_err_vec = r_first_err;

endmodule
